// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if: valid/ready word handshake into the UART transmitter.
interface uart_tx_frame_if #(parameter int DATA_WD = 8);
  logic [DATA_WD-1:0] P_DATA;
  logic               Data_Valid;
  logic               Data_Ready;
  modport master (output P_DATA, Data_Valid, input Data_Ready);
  modport slave (input P_DATA, Data_Valid, output Data_Ready);
endinterface

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: prescaled UART transmitter with a one-word holding register,
// optional parity and 1/2 stop bits; frames chain back-to-back with no idle gap.
module uart_tx_frame #(
  parameter int DATA_WD  = 8,
  parameter int PRESC_WD = 8
) (
  input  logic                CLK,
  input  logic                RST,
  uart_tx_frame_if.slave      s_if,
  input  logic                parity_enable,
  input  logic                parity_type,
  input  logic                stop_bits,
  input  logic [PRESC_WD-1:0] prescale,
  output logic                TX_OUT,
  output logic                busy
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t              r_state;
  logic [DATA_WD-1:0]  r_hold_data, r_shift;
  logic                r_hold_full, r_ready, r_par, r_par_en, r_stop2;
  logic [PRESC_WD-1:0] r_presc, r_cnt;
  logic [3:0]          r_idx;
  logic                w_bit_end, w_last_stop, w_load, w_accept;
  assign s_if.Data_Ready = r_ready;
  assign w_accept    = s_if.Data_Valid && r_ready;
  assign w_bit_end   = r_cnt == r_presc - 1'b1;
  assign w_last_stop = r_state == STOP && w_bit_end && r_idx == {3'b000, r_stop2};
  // the shifter is free while idle or on the very last cycle of the final stop bit
  assign w_load      = r_hold_full && (r_state == IDLE || w_last_stop);
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= IDLE;
      r_hold_data <= '0;
      r_shift     <= '0;
      r_hold_full <= 1'b0;
      r_ready     <= 1'b1;
      r_par       <= 1'b0;
      r_par_en    <= 1'b0;
      r_stop2     <= 1'b0;
      r_presc     <= '0;
      r_cnt       <= '0;
      r_idx       <= '0;
      TX_OUT      <= 1'b1;
      busy        <= 1'b0;
    end else begin
      if (w_accept) begin
        r_hold_data <= s_if.P_DATA;
        r_hold_full <= 1'b1;
        r_ready     <= 1'b0;
      end
      r_cnt <= (r_state == IDLE || w_bit_end) ? '0 : r_cnt + 1'b1;
      if (w_load) begin
        r_shift     <= r_hold_data;
        r_hold_full <= 1'b0;
        r_ready     <= 1'b1;
        r_par       <= ^r_hold_data ^ parity_type;
        r_par_en    <= parity_enable;
        r_stop2     <= stop_bits;
        r_presc     <= prescale == '0 ? PRESC_WD'(1) : prescale;
        r_idx       <= '0;
        r_state     <= START;
        TX_OUT      <= 1'b0;
        busy        <= 1'b1;
      end else if (w_bit_end) begin
        case (r_state)
          START: begin
            r_state <= DATA;
            TX_OUT  <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_idx   <= '0;
          end
          DATA: begin
            if (r_idx == 4'(DATA_WD - 1)) begin
              r_state <= r_par_en ? PARITY : STOP;
              TX_OUT  <= r_par_en ? r_par : 1'b1;
              r_idx   <= '0;
            end else begin
              r_idx   <= r_idx + 1'b1;
              TX_OUT  <= r_shift[0];
              r_shift <= r_shift >> 1;
            end
          end
          PARITY: begin
            r_state <= STOP;
            TX_OUT  <= 1'b1;
            r_idx   <= '0;
          end
          STOP: begin
            r_state <= w_last_stop ? IDLE : STOP;
            busy    <= !w_last_stop;
            r_idx   <= r_idx + 1'b1;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed frame vectors on 8- and 7-bit instances plus
// back-to-back and mid-frame reset sequences.
module tb_uart_tx_frame;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       parity_enable = 1'b0, parity_type = 1'b0, stop_bits = 1'b0;
  logic [7:0] prescale = 8'd1;
  logic       tx8, busy8, tx7, busy7;
  int         n_err = 0, n_chk = 0;

  uart_tx_frame_if #(.DATA_WD(8)) if8 ();
  uart_tx_frame_if #(.DATA_WD(7)) if7 ();

  uart_tx_frame #(.DATA_WD(8), .PRESC_WD(8)) dut8 (
    .CLK(clk), .RST(rst_n), .s_if(if8.slave), .parity_enable(parity_enable),
    .parity_type(parity_type), .stop_bits(stop_bits), .prescale(prescale),
    .TX_OUT(tx8), .busy(busy8));

  uart_tx_frame #(.DATA_WD(7), .PRESC_WD(8)) dut7 (
    .CLK(clk), .RST(rst_n), .s_if(if7.slave), .parity_enable(parity_enable),
    .parity_type(parity_type), .stop_bits(stop_bits), .prescale(prescale),
    .TX_OUT(tx7), .busy(busy7));

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] data;
    bit         pe, pt, st, w7;
    logic [7:0] presc;
    string      seq;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int eff;
    eff = (v.presc == 0) ? 1 : int'(v.presc);
    parity_enable = v.pe; parity_type = v.pt; stop_bits = v.st; prescale = v.presc;
    @(negedge clk);
    chk($sformatf("v%0d ready_idle", k), v.w7 ? if7.Data_Ready : if8.Data_Ready, 1);
    if (v.w7) begin if7.P_DATA = v.data[6:0]; if7.Data_Valid = 1'b1; end
    else begin if8.P_DATA = v.data[7:0]; if8.Data_Valid = 1'b1; end
    @(posedge clk);
    #1 if7.Data_Valid = 1'b0; if8.Data_Valid = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d ready_fall", k), v.w7 ? if7.Data_Ready : if8.Data_Ready, 0);
    chk($sformatf("v%0d busy_pre", k), v.w7 ? busy7 : busy8, 0);
    for (int i = 0; i < v.seq.len() * eff; i++) begin
      @(negedge clk);
      chk($sformatf("v%0d tx[%0d]", k, i), v.w7 ? tx7 : tx8, (v.seq[i / eff] == "1") ? 1 : 0);
      chk($sformatf("v%0d busy[%0d]", k, i), v.w7 ? busy7 : busy8, 1);
      if (i == 0) chk($sformatf("v%0d ready_back", k), v.w7 ? if7.Data_Ready : if8.Data_Ready, 1);
      if (i == 1) begin
        prescale = v.presc + 8'd3; parity_enable = ~v.pe;
        parity_type = ~v.pt; stop_bits = ~v.st;
      end
    end
    @(negedge clk);
    chk($sformatf("v%0d tx_end", k), v.w7 ? tx7 : tx8, 1);
    chk($sformatf("v%0d busy_end", k), v.w7 ? busy7 : busy8, 0);
  endtask

  vec_t vecs[7];

  initial begin
    // seq lists line levels per bit period, starting with the start bit
    vecs[0] = '{data: 9'h0A3, pe: 0, pt: 0, st: 0, w7: 0, presc: 8'd1, seq: "0110001011"};
    vecs[1] = '{data: 9'h0B4, pe: 1, pt: 0, st: 0, w7: 0, presc: 8'd1, seq: "00010110101"};
    vecs[2] = '{data: 9'h0D2, pe: 1, pt: 1, st: 0, w7: 0, presc: 8'd1, seq: "00100101111"};
    vecs[3] = '{data: 9'h055, pe: 0, pt: 0, st: 1, w7: 0, presc: 8'd4, seq: "01010101011"};
    vecs[4] = '{data: 9'h00F, pe: 1, pt: 0, st: 1, w7: 0, presc: 8'd0, seq: "011110000011"};
    vecs[5] = '{data: 9'h080, pe: 1, pt: 1, st: 0, w7: 0, presc: 8'd3, seq: "00000000101"};
    vecs[6] = '{data: 9'h07F, pe: 1, pt: 1, st: 0, w7: 1, presc: 8'd1, seq: "0111111101"};
    if8.Data_Valid = 1'b0; if8.P_DATA = '0;
    if7.Data_Valid = 1'b0; if7.P_DATA = '0;
    #12;
    chk("rst tx", tx8, 1);
    chk("rst busy", busy8, 0);
    chk("rst ready", if8.Data_Ready, 1);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst tx", tx8, 1);
    chk("post_rst busy", busy8, 0);

    for (int k = 0; k < 7; k++) run_vec(k, vecs[k]);

    // back-to-back 0x01 then 0xFE, with a third word stalled while the hold is full
    parity_enable = 0; parity_type = 0; stop_bits = 0; prescale = 8'd1;
    begin
      string s2 = "01000000010011111111";
      for (int n = 0; n < 26; n++) begin
        @(negedge clk);
        if (n >= 2 && n < 22) begin
          chk($sformatf("b2b tx[%0d]", n - 2), tx8, (s2[n - 2] == "1") ? 1 : 0);
          chk($sformatf("b2b busy[%0d]", n - 2), busy8, 1);
        end
        if (n == 1 || (n >= 4 && n <= 11)) chk($sformatf("b2b ready_low[%0d]", n), if8.Data_Ready, 0);
        if (n == 12) chk("b2b ready_back", if8.Data_Ready, 1);
        if (n >= 22) begin
          chk($sformatf("b2b idle_tx[%0d]", n), tx8, 1);
          chk($sformatf("b2b idle_busy[%0d]", n), busy8, 0);
          chk($sformatf("b2b idle_ready[%0d]", n), if8.Data_Ready, 1);
        end
        if (n == 0) begin if8.P_DATA = 8'h01; if8.Data_Valid = 1'b1; end
        if (n == 1) if8.Data_Valid = 1'b0;
        if (n == 3) begin if8.P_DATA = 8'hFE; if8.Data_Valid = 1'b1; end
        if (n == 4) if8.P_DATA = 8'h33;
        if (n == 11) if8.Data_Valid = 1'b0;
      end
    end

    // reset during the 4th data bit of 0xA3 with 0x5A waiting in the hold register
    @(negedge clk);
    if8.P_DATA = 8'hA3; if8.Data_Valid = 1'b1;
    @(negedge clk);
    if8.Data_Valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 1) begin if8.P_DATA = 8'h5A; if8.Data_Valid = 1'b1; end
      if (i == 2) if8.Data_Valid = 1'b0;
    end
    chk("rst_mid data3", tx8, 0);
    chk("rst_mid held", if8.Data_Ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid tx", tx8, 1);
    chk("rst_mid busy", busy8, 0);
    chk("rst_mid ready", if8.Data_Ready, 1);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk($sformatf("rst_idle tx[%0d]", i), tx8, 1);
      chk($sformatf("rst_idle busy[%0d]", i), busy8, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
